stack_unit: RTL and testbench
=============================

STACK_UNIT -- requirements
Module: stack_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, number of stack entries (power of two, >=2).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port push  input  1  push din onto the stack.
REQ-006 SHALL have port pop  input  1  remove top entry and present it on dout.
REQ-007 SHALL have port tos  input  1  present top entry on dout without removing it.
REQ-008 SHALL have port clr_err  input  1  clear sticky error flags.
REQ-009 SHALL have port din  input  WIDTH  data to push.
REQ-010 SHALL have port dout  output  WIDTH  registered top-of-stack read data.
REQ-011 SHALL have port dout_valid  output  1  one-cycle pulse: dout updated by a successful pop or tos.
REQ-012 SHALL have port count  output  $clog2(DEPTH)+1  number of valid entries.
REQ-013 SHALL have port empty  output  1  count == 0.
REQ-014 SHALL have port full  output  1  count == DEPTH.
REQ-015 SHALL have port overflow  output  1  sticky: push attempted while full.
REQ-016 SHALL have port underflow  output  1  sticky: pop or tos attempted while empty.

Function
REQ-017 SHALL hold entries in a DEPTH x WIDTH register array addressed by stack pointer sp (= count); top entry is at sp-1.
REQ-018 SHALL, on push only and not full: write din to entry sp, increment count; dout unchanged, dout_valid=0.
REQ-019 SHALL, on pop only and not empty: load dout with entry sp-1, decrement count, assert dout_valid next cycle.
REQ-020 SHALL, on tos only and not empty: load dout with entry sp-1, count unchanged, assert dout_valid next cycle.
REQ-021 SHALL give read latency of exactly one cycle: dout/dout_valid reflect the command sampled on the previous edge.
REQ-022 SHALL treat pop and tos asserted together as pop.
REQ-023 SHALL, on push and pop together and not empty: load dout with old top, overwrite entry sp-1 with din, count unchanged, dout_valid=1 (replace-top).
REQ-024 SHALL, on push and pop together while empty: perform the push only, set underflow, dout_valid=0.
REQ-025 SHALL, on push while full (without pop): ignore the write, count unchanged, set overflow.
REQ-026 SHALL, on push and pop together while full: perform replace-top (REQ-023), no overflow.
REQ-027 SHALL, on pop or tos while empty (without push): leave dout and count unchanged, dout_valid=0, set underflow.
REQ-028 SHALL hold dout between reads; dout_valid SHALL be 0 in every cycle not following a successful read.
REQ-029 SHALL keep overflow/underflow set until rst or clr_err; clr_err SHALL clear them on the next edge, and an error event in the same cycle as clr_err SHALL leave the flag set.
REQ-030 SHALL derive empty and full combinationally from count; no other outputs combinational from inputs.

Reset
REQ-031 SHALL, while rst is high at a clock edge, set count=0, dout=0, dout_valid=0, overflow=0, underflow=0; all commands that cycle are ignored.
REQ-032 SHALL NOT require clearing array contents on reset; entries are undefined until written.
REQ-033 SHALL, on reset mid-operation, discard the in-flight command; the first command after rst deasserts is processed normally.

Verification
REQ-034 Bench SHALL: after reset push 0x11,0x22,0x33 then pop x3 -> dout 0x33,0x22,0x11 each one cycle after pop with dout_valid=1; empty=1 at end.
REQ-035 Bench SHALL: push 0x5A, tos twice -> dout=0x5A both times, count stays 1.
REQ-036 Bench SHALL: fill DEPTH=16 entries, push 0xFF -> full=1, count=16, overflow=1; pops return the original 16 values, never 0xFF.
REQ-037 Bench SHALL: pop on empty -> underflow=1, dout_valid=0, dout unchanged; clr_err -> underflow=0 next cycle.
REQ-038 Bench SHALL: push 0x01,0x02, then push=pop=1 with din=0x07 -> dout=0x02, count=2; pop -> dout=0x07.
REQ-039 Bench SHALL: push 0x44, assert rst together with pop -> count=0, dout=0, dout_valid=0, no underflow.

Source files
------------

// File: rtl/stack_unit.sv
// stack_unit: register-array LIFO with registered top-of-stack read port,
// replace-top (push+pop), and sticky overflow/underflow flags.
module stack_unit #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       tos,
   input  logic                       clr_err,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           dout,
   output logic                       dout_valid,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       empty,
   output logic                       full,
   output logic                       overflow,
   output logic                       underflow
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    top_idx;
   logic [AW-1:0]    wr_idx;
   logic             wr_en;

   // Status flags follow the entry count directly.
   assign empty   = (count == CW'(0));
   assign full    = (count == CW'(DEPTH));
   assign top_idx = AW'(count - CW'(1));

   // Array write port: replace-top overwrites sp-1, a plain push writes sp.
   always_comb begin
      wr_en  = 1'b0;
      wr_idx = count[AW-1:0];
      if (push && pop && !empty) begin
         wr_en  = 1'b1;
         wr_idx = top_idx;
      end else if (push && !full) begin
         wr_en = 1'b1;
      end
      if (rst) begin
         wr_en = 1'b0;
      end
   end

   // Entry storage; contents are not reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_idx] <= din;
      end
   end

   // Pointer, read data and sticky error flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         count      <= '0;
         dout       <= '0;
         dout_valid <= 1'b0;
         overflow   <= 1'b0;
         underflow  <= 1'b0;
      end else begin
         dout_valid <= 1'b0;
         // Clear first so an error in the same cycle wins.
         if (clr_err) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
         end
         if (push && pop) begin
            if (empty) begin
               count     <= count + CW'(1);
               underflow <= 1'b1;
            end else begin
               dout       <= mem[top_idx];
               dout_valid <= 1'b1;
            end
         end else if (push) begin
            if (full) begin
               overflow <= 1'b1;
            end else begin
               count <= count + CW'(1);
            end
         end else if (pop || tos) begin
            if (empty) begin
               underflow <= 1'b1;
            end else begin
               dout       <= mem[top_idx];
               dout_valid <= 1'b1;
               if (pop) begin
                  count <= count - CW'(1);
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_stack_unit.sv
// tb_stack_unit: directed scenarios plus random traffic, every cycle compared
// against a queue-based LIFO model.
module tb_stack_unit;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned CW    = $clog2(DEPTH) + 1;

   logic             clk = 1'b0;
   logic             rst, push, pop, tos, clr_err;
   logic [WIDTH-1:0] din;
   logic [WIDTH-1:0] dout;
   logic             dout_valid, empty, full, overflow, underflow;
   logic [CW-1:0]    count;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   logic [WIDTH-1:0] q [$];
   logic [WIDTH-1:0] m_dout;
   logic             m_dv, m_ov, m_uf;

   stack_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .push       (push),
      .pop        (pop),
      .tos        (tos),
      .clr_err    (clr_err),
      .din        (din),
      .dout       (dout),
      .dout_valid (dout_valid),
      .count      (count),
      .empty      (empty),
      .full       (full),
      .overflow   (overflow),
      .underflow  (underflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Model of one clock edge, written from the LIFO behaviour.
   task automatic model_edge(input logic r, input logic pu, input logic po,
                             input logic to, input logic cl, input logic [WIDTH-1:0] d);
      if (r) begin
         q.delete();
         m_dout = '0; m_dv = 1'b0; m_ov = 1'b0; m_uf = 1'b0;
      end else begin
         m_dv = 1'b0;
         if (cl) begin m_ov = 1'b0; m_uf = 1'b0; end
         if (pu && po) begin
            if (q.size() == 0) begin
               q.push_back(d);
               m_uf = 1'b1;
            end else begin
               m_dout = q[$];
               q[q.size()-1] = d;
               m_dv = 1'b1;
            end
         end else if (pu) begin
            if (q.size() == DEPTH) m_ov = 1'b1;
            else q.push_back(d);
         end else if (po || to) begin
            if (q.size() == 0) m_uf = 1'b1;
            else begin
               m_dout = q[$];
               m_dv = 1'b1;
               if (po) void'(q.pop_back());
            end
         end
      end
   endtask

   task automatic check_all();
      chk("count",      32'(count),      32'(q.size()));
      chk("empty",      32'(empty),      32'(q.size() == 0));
      chk("full",       32'(full),       32'(q.size() == DEPTH));
      chk("dout",       32'(dout),       32'(m_dout));
      chk("dout_valid", 32'(dout_valid), 32'(m_dv));
      chk("overflow",   32'(overflow),   32'(m_ov));
      chk("underflow",  32'(underflow),  32'(m_uf));
   endtask

   // Drive one cycle of inputs, advance model and DUT, then compare.
   task automatic cyc(input logic r, input logic pu, input logic po,
                      input logic to, input logic cl, input logic [WIDTH-1:0] d);
      @(negedge clk);
      rst = r; push = pu; pop = po; tos = to; clr_err = cl; din = d;
      @(posedge clk);
      model_edge(r, pu, po, to, cl, d);
      #1;
      check_all();
   endtask

   task automatic idle();
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
   endtask

   initial begin
      logic r, pu, po, to, cl;
      rst = 1'b1; push = 1'b0; pop = 1'b0; tos = 1'b0; clr_err = 1'b0; din = '0;
      q.delete();
      m_dout = '0; m_dv = 1'b0; m_ov = 1'b0; m_uf = 1'b0;

      // Reset state
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      chk("reset_count_zero", 32'(count), 32'd0);

      // Push three, pop three in LIFO order
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h11);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h22);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h33);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      chk("pop1_dout", 32'(dout), 32'h33);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      chk("pop2_dout", 32'(dout), 32'h22);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      chk("pop3_dout", 32'(dout), 32'h11);
      chk("pop3_empty", 32'(empty), 32'd1);
      idle();

      // Peek twice
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h5A);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
      chk("tos_dout", 32'(dout), 32'h5A);
      chk("tos_count", 32'(count), 32'd1);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);

      // Fill, overflow, drain
      for (int i = 0; i < DEPTH; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'(i * 7 + 3));
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF);
      chk("ovf_full", 32'(full), 32'd1);
      chk("ovf_count", 32'(count), 32'd16);
      chk("ovf_flag", 32'(overflow), 32'd1);
      // Replace-top while full does not add an overflow source
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'hC3);
      chk("full_replace_no_ovf", 32'(overflow), 32'd0);
      for (int i = 0; i < DEPTH; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);

      // Underflow, sticky, then clear
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      chk("udf_flag", 32'(underflow), 32'd1);
      chk("udf_dv", 32'(dout_valid), 32'd0);
      idle();
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
      chk("clr_udf", 32'(underflow), 32'd0);
      // Error coincident with clear stays set
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
      chk("clr_and_udf", 32'(underflow), 32'd1);
      // Push+pop on empty: push only, underflow
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h9C);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
      chk("pushpop_empty_data", 32'(dout), 32'h9C);

      // Replace-top
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h01);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h02);
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h07);
      chk("replace_dout", 32'(dout), 32'h02);
      chk("replace_count", 32'(count), 32'd2);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      chk("replace_pop", 32'(dout), 32'h07);

      // Reset with pop in flight
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h44);
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      chk("rst_pop_count", 32'(count), 32'd0);
      chk("rst_pop_dv", 32'(dout_valid), 32'd0);
      chk("rst_pop_udf", 32'(underflow), 32'd0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h66);

      // Random traffic
      for (int n = 0; n < 600; n++) begin
         r  = ($urandom_range(0, 79) == 0);
         pu = ($urandom_range(0, 1) == 1);
         po = ($urandom_range(0, 2) == 0);
         to = ($urandom_range(0, 4) == 0);
         cl = ($urandom_range(0, 11) == 0);
         if (pu && to && !po) to = 1'b0;
         cyc(r, pu, po, to, cl, 8'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
